// File: rtl/lsu_align.sv
// Load/store alignment unit: aligned accesses pass straight through, misaligned
// halfword/word accesses are split into sequential byte accesses with stall.
module lsu_align #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic [31:0] rdata_out,
  output logic        stall,
  output logic        misalign_err,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_WriteData,
  input  logic [31:0] mem_ReadData
);

  localparam int DATA_W = 32;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [7:0]  buf0, buf1, buf2;

  logic              is_wr, is_rd, req;
  logic [1:0]        size_m1;
  logic              misaligned, split_go, in_split, last;
  logic [1:0]        k;
  logic [7:0]        live;
  logic [DATA_W-1:0] load_word;

  function automatic logic [DATA_W-1:0] extend_half(input logic [15:0] h, input logic zext);
    logic signed [DATA_W-1:0] s;
    s = $signed(h);
    return zext ? {16'b0, h} : s;
  endfunction

  assign is_wr = MemWrite_in;
  assign is_rd = MemRead_in & ~MemWrite_in;
  assign req   = MemRead_in | MemWrite_in;
  assign live  = mem_ReadData[7:0];

  always_comb begin
    size_m1 = 2'd3;
    case (funct3_in)
      3'b000, 3'b100: size_m1 = 2'd0;
      3'b001, 3'b101: size_m1 = 2'd1;
      default:        size_m1 = 2'd3;
    endcase
  end

  assign misaligned = ((size_m1 == 2'd1) & addr_in[0]) |
                      ((size_m1 == 2'd3) & (|addr_in[1:0]));
  assign split_go   = req & misaligned & SPLIT_EN;
  assign in_split   = (state == SPLIT) ? req : split_go;
  assign k          = (state == SPLIT) ? cnt : 2'd0;
  assign last       = (k == size_m1);
  assign load_word  = (size_m1 == 2'd1) ? extend_half({live, buf0}, funct3_in[2])
                                        : {live, buf2, buf1, buf0};

  always_comb begin
    mem_MemRead   = MemRead_in;
    mem_MemWrite  = MemWrite_in;
    mem_funct3    = funct3_in;
    mem_addr      = addr_in;
    mem_WriteData = wdata_in;
    rdata_out     = mem_ReadData;
    stall         = 1'b0;
    misalign_err  = 1'b0;
    if (state == SPLIT && !req) begin
      // request vanished mid-split: abort without issuing anything
      mem_MemRead  = 1'b0;
      mem_MemWrite = 1'b0;
      rdata_out    = '0;
    end else if (in_split) begin
      mem_MemRead   = is_rd;
      mem_MemWrite  = is_wr;
      mem_funct3    = is_wr ? 3'b000 : 3'b100;
      mem_addr      = addr_in + {30'b0, k};
      mem_WriteData = {24'b0, wdata_in[{k, 3'b000} +: 8]};
      rdata_out     = (last && is_rd) ? load_word : '0;
      stall         = ~last;
    end else if (req && misaligned && !SPLIT_EN) begin
      mem_MemRead  = 1'b0;
      mem_MemWrite = 1'b0;
      rdata_out    = '0;
      misalign_err = 1'b1;
    end
    if (!rst_n) begin
      mem_MemRead  = 1'b0;
      mem_MemWrite = 1'b0;
      rdata_out    = '0;
      stall        = 1'b0;
      misalign_err = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      buf0  <= 8'h00;
      buf1  <= 8'h00;
      buf2  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (split_go) begin
            state <= SPLIT;
            cnt   <= 2'd1;
            if (is_rd) buf0 <= live;
          end
        end
        SPLIT: begin
          if (!req || last) begin
            state <= IDLE;
            cnt   <= 2'd0;
          end else begin
            cnt <= cnt + 2'd1;
            if (is_rd) begin
              case (cnt)
                2'd1:    buf1 <= live;
                2'd2:    buf2 <= live;
                default: ;
              endcase
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: directed scenarios plus randomized back-to-back traffic
// against a byte-array memory and a size/extension reference model.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead_in, MemWrite_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, wdata_in;

  logic [31:0] rdata_out, mem_addr, mem_WriteData, mem_ReadData;
  logic        stall, misalign_err, mem_MemRead, mem_MemWrite;
  logic [2:0]  mem_funct3;

  logic [31:0] e0_rdata_out, e0_mem_addr, e0_mem_WriteData, e0_mem_ReadData;
  logic        e0_stall, e0_misalign_err, e0_mem_MemRead, e0_mem_MemWrite;
  logic [2:0]  e0_mem_funct3;

  int n_vec = 0;
  int n_err = 0;

  bit [7:0] mem [0:1023];

  always #5 clk = ~clk;

  lsu_align #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .rdata_out(rdata_out), .stall(stall), .misalign_err(misalign_err),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_WriteData(mem_WriteData), .mem_ReadData(mem_ReadData)
  );

  lsu_align #(.SPLIT_EN(1'b0)) dut_nosplit (
    .clk(clk), .rst_n(rst_n), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .rdata_out(e0_rdata_out), .stall(e0_stall), .misalign_err(e0_misalign_err),
    .mem_MemRead(e0_mem_MemRead), .mem_MemWrite(e0_mem_MemWrite), .mem_funct3(e0_mem_funct3),
    .mem_addr(e0_mem_addr), .mem_WriteData(e0_mem_WriteData), .mem_ReadData(e0_mem_ReadData)
  );

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = size_of(f3);
    return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
  endfunction

  // Value an access of this size/sign returns when the bytes at a, a+1, ... are read.
  function automatic logic [31:0] mem_load(input logic [31:0] a, input logic [2:0] f3);
    int n;
    logic [31:0] v, ai;
    n = size_of(f3);
    v = 0;
    for (int i = 0; i < n; i++) begin
      ai = a + i;
      v = v + ({24'b0, mem[ai[9:0]]} << (8 * i));
    end
    if (n == 1 && !f3[2] && v[7])  v = v + 32'hFFFF_FF00;
    if (n == 2 && !f3[2] && v[15]) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  always_comb mem_ReadData    = mem_load(mem_addr, mem_funct3);
  always_comb e0_mem_ReadData = mem_load(e0_mem_addr, e0_mem_funct3);

  always @(posedge clk) begin
    if (mem_MemWrite) begin
      for (int i = 0; i < size_of(mem_funct3); i++)
        mem[10'(mem_addr + i)] <= mem_WriteData[8*i +: 8];
    end
  end

  task automatic step(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    MemRead_in = rd; MemWrite_in = wr; funct3_in = f3; addr_in = a; wdata_in = wd;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    MemRead_in = 1'b1; MemWrite_in = 1'b0; funct3_in = 3'b010; addr_in = 32'h1; wdata_in = 0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %0b want 0", stall); end
    n_vec++; if ({mem_MemRead, mem_MemWrite} !== 2'b00) begin n_err++; $display("FAIL rst_strobes got %b want 00", {mem_MemRead, mem_MemWrite}); end
    n_vec++; if (rdata_out !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", rdata_out); end
    n_vec++; if (e0_misalign_err !== 1'b0) begin n_err++; $display("FAIL rst_misalign_err got %0b want 0", e0_misalign_err); end
    @(negedge clk);
    rst_n = 1'b1; MemRead_in = 1'b0;
  endtask

  task automatic test_aligned_lw;
    step(0, 1, 3'b010, 32'h10, 32'h1234_5678);
    n_vec++; if (mem_MemWrite !== 1'b1 || mem_addr !== 32'h10 || mem_WriteData !== 32'h1234_5678)
      begin n_err++; $display("FAIL sw_pass got we=%0b a=%h d=%h want 1 10 12345678", mem_MemWrite, mem_addr, mem_WriteData); end
    step(1, 0, 3'b010, 32'h10, 32'h0);
    n_vec++; if (rdata_out !== 32'h1234_5678) begin n_err++; $display("FAIL lw_rdata got %h want 12345678", rdata_out); end
    n_vec++; if (stall !== 1'b0 || mem_funct3 !== 3'b010) begin n_err++; $display("FAIL lw_ctl got stall=%0b f3=%b want 0 010", stall, mem_funct3); end
  endtask

  task automatic test_misaligned_sw;
    logic [31:0] wd = 32'hAABB_CCDD;
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 3'b010, 32'h101, wd);
      n_vec++; if (mem_MemWrite !== 1'b1 || mem_funct3 !== 3'b000 || mem_addr !== 32'h101 + k)
        begin n_err++; $display("FAIL sw_split%0d got we=%0b f3=%b a=%h want 1 000 %h", k, mem_MemWrite, mem_funct3, mem_addr, 32'h101 + k); end
      n_vec++; if (mem_WriteData[7:0] !== wd[8*k +: 8] || stall !== (k < 3))
        begin n_err++; $display("FAIL sw_byte%0d got d=%h stall=%0b want %h %0b", k, mem_WriteData[7:0], stall, wd[8*k +: 8], k < 3); end
    end
    step(1, 0, 3'b010, 32'h100, 32'h0);
    n_vec++; if (rdata_out !== 32'hBBCC_DD00) begin n_err++; $display("FAIL sw_readback got %h want bbccdd00", rdata_out); end
  endtask

  task automatic test_lh_lhu;
    step(0, 1, 3'b000, 32'h3, 32'h80);
    step(0, 1, 3'b000, 32'h4, 32'hFF);
    for (int u = 0; u < 2; u++) begin
      step(1, 0, u ? 3'b101 : 3'b001, 32'h3, 32'h0);
      n_vec++; if (stall !== 1'b1 || rdata_out !== 32'h0 || mem_funct3 !== 3'b100 || mem_addr !== 32'h3)
        begin n_err++; $display("FAIL lh%0d_c0 got stall=%0b r=%h f3=%b a=%h want 1 0 100 3", u, stall, rdata_out, mem_funct3, mem_addr); end
      step(1, 0, u ? 3'b101 : 3'b001, 32'h3, 32'h0);
      n_vec++; if (stall !== 1'b0 || rdata_out !== (u ? 32'h0000_FF80 : 32'hFFFF_FF80))
        begin n_err++; $display("FAIL lh%0d_c1 got stall=%0b r=%h want 0 %h", u, stall, rdata_out, u ? 32'h0000_FF80 : 32'hFFFF_FF80); end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] a = 32'hFFFF_FFFE;
    for (int k = 0; k < 4; k++) step(0, 1, 3'b000, a + k, 32'h11 * (k + 1));
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 3'b010, a, 32'h0);
      n_vec++; if (mem_addr !== a + k || stall !== (k < 3))
        begin n_err++; $display("FAIL wrap_addr%0d got a=%h stall=%0b want %h %0b", k, mem_addr, stall, a + k, k < 3); end
    end
    n_vec++; if (rdata_out !== 32'h4433_2211) begin n_err++; $display("FAIL wrap_rdata got %h want 44332211", rdata_out); end
  endtask

  task automatic test_reset_mid;
    step(0, 1, 3'b010, 32'h201, 32'h5566_7788);
    step(0, 1, 3'b010, 32'h201, 32'h5566_7788);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (stall !== 1'b0 || mem_MemWrite !== 1'b0)
      begin n_err++; $display("FAIL rstmid_out got stall=%0b we=%0b want 0 0", stall, mem_MemWrite); end
    @(negedge clk);
    rst_n = 1'b1; MemWrite_in = 1'b0;
    step(0, 1, 3'b000, 32'h300, 32'hEE);
    n_vec++; if (stall !== 1'b0 || mem_MemWrite !== 1'b1 || mem_addr !== 32'h300)
      begin n_err++; $display("FAIL rstmid_sb got stall=%0b we=%0b a=%h want 0 1 300", stall, mem_MemWrite, mem_addr); end
    step(1, 0, 3'b010, 32'h200, 32'h0);
    n_vec++; if (rdata_out !== 32'h0077_8800) begin n_err++; $display("FAIL rstmid_bytes got %h want 00778800", rdata_out); end
    step(1, 0, 3'b100, 32'h204, 32'h0);
    n_vec++; if (rdata_out !== 32'h0) begin n_err++; $display("FAIL rstmid_byte3 got %h want 0", rdata_out); end
  endtask

  task automatic test_abort;
    step(1, 0, 3'b010, 32'h41, 32'h0);
    step(0, 0, 3'b010, 32'h41, 32'h0);
    n_vec++; if ({mem_MemRead, mem_MemWrite} !== 2'b00 || stall !== 1'b0)
      begin n_err++; $display("FAIL abort_out got strobes=%b stall=%0b want 00 0", {mem_MemRead, mem_MemWrite}, stall); end
    step(1, 0, 3'b100, 32'h41, 32'h0);
    n_vec++; if (mem_addr !== 32'h41 || stall !== 1'b0 || mem_MemRead !== 1'b1)
      begin n_err++; $display("FAIL abort_idle got a=%h stall=%0b re=%0b want 41 0 1", mem_addr, stall, mem_MemRead); end
  endtask

  task automatic test_split_en0;
    for (int c = 0; c < 2; c++) begin
      step(1, 0, 3'b001, 32'h1, 32'h0);
      n_vec++; if (e0_misalign_err !== 1'b1 || {e0_mem_MemRead, e0_mem_MemWrite} !== 2'b00 || e0_stall !== 1'b0 || e0_rdata_out !== 32'h0)
        begin n_err++; $display("FAIL nosplit_lh%0d got err=%0b strobes=%b stall=%0b r=%h want 1 00 0 0", c, e0_misalign_err, {e0_mem_MemRead, e0_mem_MemWrite}, e0_stall, e0_rdata_out); end
    end
    step(1, 0, 3'b001, 32'h2, 32'h0);
    n_vec++; if (e0_misalign_err !== 1'b0 || e0_mem_MemRead !== 1'b1 || e0_rdata_out !== 32'hFFFF_8000)
      begin n_err++; $display("FAIL nosplit_aligned got err=%0b re=%0b r=%h want 0 1 ffff8000", e0_misalign_err, e0_mem_MemRead, e0_rdata_out); end
  endtask

  // Random loads/stores issued back to back, misaligned ones immediately following each other.
  task automatic test_back_to_back;
    logic [2:0] ld_f3 [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    for (int t = 0; t < 60; t++) begin
      logic wr;
      logic [2:0] f3;
      logic [31:0] a, wd, exp;
      int n, cyc;
      bit mis;
      wr  = 1'($urandom_range(0, 1));
      f3  = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 5)];
      a   = ($urandom() & 32'hFFFF_FC00) | (32'h240 + $urandom_range(0, 63));
      wd  = $urandom();
      n   = size_of(f3);
      mis = is_mis(f3, a);
      cyc = mis ? n : 1;
      exp = mem_load(a, f3);
      for (int k = 0; k < cyc; k++) begin
        step(!wr, wr, f3, a, wd);
        n_vec++; if (stall !== (k < cyc - 1) || e0_misalign_err !== mis)
          begin n_err++; $display("FAIL rnd%0d_ctl k=%0d got stall=%0b err=%0b want %0b %0b", t, k, stall, e0_misalign_err, k < cyc - 1, mis); end
        n_vec++; if (mem_addr !== (mis ? a + k : a) || mem_funct3 !== (mis ? (wr ? 3'b000 : 3'b100) : f3) ||
                     mem_MemWrite !== wr || mem_MemRead !== !wr)
          begin n_err++; $display("FAIL rnd%0d_mem k=%0d got a=%h f3=%b we=%0b re=%0b want %h", t, k, mem_addr, mem_funct3, mem_MemWrite, mem_MemRead, mis ? a + k : a); end
        if (!wr) begin
          n_vec++; if (rdata_out !== ((k == cyc - 1) ? exp : 32'h0))
            begin n_err++; $display("FAIL rnd%0d_rdata k=%0d got %h want %h", t, k, rdata_out, (k == cyc - 1) ? exp : 32'h0); end
        end
      end
      if (wr) begin
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
          n_vec++; if (mem[10'(a + k)] !== wd[8*k +: 8])
            begin n_err++; $display("FAIL rnd%0d_store byte%0d got %h want %h", t, k, mem[10'(a + k)], wd[8*k +: 8]); end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_aligned_lw;
    test_misaligned_sw;
    test_lh_lhu;
    test_wrap;
    test_reset_mid;
    test_abort;
    test_split_en0;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
